// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encodings,
// decoded opcodes, ALU class codes and the control-word layout.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EX   = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   function automatic logic is_mem_state(state_t s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Moore output decode: maps an FSM state to its raw (ungated) control word.
module mips_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.alu_src_b = 2'b01;
            ctrl.alu_op    = ALU_ADD;
         end
         S_DECODE: begin
            ctrl.alu_src_b = 2'b11;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_ADDR, S_ADDI_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
         end
         S_MEM_READ: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_R_WB: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = 2'b01;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = 2'b10;
         end
         S_ADDI_WB: ctrl.reg_write = 1'b1;
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM with retired-instruction counter.
// Define MEM_HANDSHAKE_EN to make memory states wait on mem_ready.
module mips_multicycle_controller
   import mips_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        i_or_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        mem_to_reg,
   output logic        reg_dst,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  pc_source,
   output logic        illegal_op,
   output logic [3:0]  state,
   output logic [31:0] retired
);

   state_t cur_state, nxt_state, dec_state;
   ctrl_t  raw;
   logic   mem_done, illegal_dec, retire, strobe_en;
   logic   inputs_unused;

   // funct only matters to the ALU control downstream; zero is consumed by the datapath
`ifdef MEM_HANDSHAKE_EN
   assign mem_done      = mem_ready;
   assign inputs_unused = ^{funct, zero};
`else
   assign mem_done      = 1'b1;
   assign inputs_unused = ^{funct, zero, mem_ready};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state  <= S_FETCH;
         retired    <= '0;
         illegal_op <= 1'b0;
      end else begin
         cur_state  <= nxt_state;
         illegal_op <= illegal_dec;
         if (retire) retired <= retired + 32'd1;
      end
   end

   always_comb begin
      nxt_state   = cur_state;
      illegal_dec = 1'b0;
      retire      = 1'b0;
      case (cur_state)
         S_FETCH:     if (mem_done) nxt_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:     nxt_state = S_EXECUTE;
               OP_LW, OP_SW: nxt_state = S_MEM_ADDR;
               OP_BEQ:       nxt_state = S_BRANCH;
               OP_J:         nxt_state = S_JUMP;
               OP_ADDI:      nxt_state = S_ADDI_EX;
               default: begin
                  nxt_state   = S_FETCH;
                  illegal_dec = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR:  nxt_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  if (mem_done) nxt_state = S_MEM_WB;
         S_MEM_WRITE: begin
            if (mem_done) begin
               nxt_state = S_FETCH;
               retire    = 1'b1;
            end
         end
         S_EXECUTE:   nxt_state = S_R_WB;
         S_ADDI_EX:   nxt_state = S_ADDI_WB;
         S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
            nxt_state = S_FETCH;
            retire    = 1'b1;
         end
         default:     nxt_state = S_FETCH;
      endcase
   end

   // Reset decodes as FETCH; write strobes fire only in the completing memory cycle
   assign dec_state = rst ? S_FETCH : cur_state;
   assign strobe_en = !rst && (!is_mem_state(cur_state) || mem_done);

   mips_ctrl_decode u_decode (
      .state (dec_state),
      .ctrl  (raw)
   );

   assign pc_write      = raw.pc_write  & strobe_en;
   assign ir_write      = raw.ir_write  & strobe_en;
   assign reg_write     = raw.reg_write & strobe_en;
   assign mem_write     = raw.mem_write & ~rst;
   assign pc_write_cond = raw.pc_write_cond;
   assign i_or_d        = raw.i_or_d;
   assign mem_read      = raw.mem_read;
   assign mem_to_reg    = raw.mem_to_reg;
   assign reg_dst       = raw.reg_dst;
   assign alu_src_a     = raw.alu_src_a;
   assign alu_src_b     = raw.alu_src_b;
   assign alu_op        = raw.alu_op;
   assign pc_source     = raw.pc_source;
   assign state         = cur_state;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Scoreboard bench: instruction-level model expands each opcode into its state
// path, queues per-cycle expectations, and a negedge monitor compares them.
module tb_mips_multicycle_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  opcode = '0, funct = '0;
   logic        zero = 1'b0, mem_ready = 1'b0;
   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic [3:0]  state;
   logic [31:0] retired;

   always #5 clk = ~clk;

   mips_multicycle_controller dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op),
      .state(state), .retired(retired)
   );

   typedef struct packed {
      logic [3:0]  st;
      logic [15:0] ctl;
      logic        ill;
      logic [31:0] ret;
   } exp_t;

   exp_t        q[$];
   int unsigned n_vec = 0, n_bad = 0;
   int unsigned m_ret = 0;
   bit          m_ill = 1'b0;

   // Control word as listed per state, then gated for memory waits and reset
   function automatic logic [15:0] ctl_of(int s, bit done, bit in_rst);
      logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa;
      logic [1:0] asb, aop, psrc;
      {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa} = '0;
      asb = 2'b00; aop = 2'b00; psrc = 2'b00;
      case (in_rst ? 0 : s)
         0:  begin mr = 1; irw = 1; pw = 1; asb = 2'b01; end
         1:  asb = 2'b11;
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mr = 1; iod = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mw = 1; iod = 1; end
         6:  begin asa = 1; aop = 2'b10; end
         7:  begin rd = 1; rw = 1; end
         8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
         9:  begin pw = 1; psrc = 2'b10; end
         10: begin asa = 1; asb = 2'b10; end
         11: rw = 1;
         default: ;
      endcase
      if (!done || in_rst) begin pw = 0; irw = 0; rw = 0; end
      if (in_rst) mw = 0;
      return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("state", 32'(state), 32'(e.st));
         check("controls", 32'({pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                                ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                                alu_src_b, alu_op, pc_source}), 32'(e.ctl));
         check("illegal_op", 32'(illegal_op), 32'(e.ill));
         check("retired", retired, e.ret);
      end
   end

   task automatic emit(input int s, input bit done, input bit in_rst);
      q.push_back('{st: 4'(s), ctl: ctl_of(s, done, in_rst), ill: m_ill, ret: m_ret});
      m_ill = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic plain(input int s, input int z);
      mem_ready = 1'($urandom);
      zero = (z < 0) ? 1'($urandom) : 1'(z);
      emit(s, 1'b1, 1'b0);
   endtask

   task automatic mem_cycles(input int s, input int fixed_wait, input int z);
`ifdef MEM_HANDSHAKE_EN
      int w;
      w = (fixed_wait >= 0) ? fixed_wait
                            : (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
      for (int i = 0; i < w; i++) begin
         mem_ready = 1'b0;
         zero = (z < 0) ? 1'($urandom) : 1'(z);
         emit(s, 1'b0, 1'b0);
      end
      mem_ready = 1'b1;
`else
      mem_ready = (fixed_wait >= 0) ? 1'b0 : 1'($urandom);
`endif
      zero = (z < 0) ? 1'($urandom) : 1'(z);
      emit(s, 1'b1, 1'b0);
   endtask

   task automatic run_instr(input logic [5:0] op, input int fixed_wait, input int z);
      bit legal;
      legal  = 1'b1;
      opcode = op;
      funct  = 6'($urandom);
      mem_cycles(0, fixed_wait, z);
      plain(1, z);
      case (op)
         6'b100011: begin plain(2, z); mem_cycles(3, fixed_wait, z); plain(4, z); end
         6'b101011: begin plain(2, z); mem_cycles(5, fixed_wait, z); end
         6'b000000: begin plain(6, z); plain(7, z); end
         6'b000100: plain(8, z);
         6'b000010: plain(9, z);
         6'b001000: begin plain(10, z); plain(11, z); end
         default:   legal = 1'b0;
      endcase
      if (legal) m_ret++;
      else m_ill = 1'b1;
   endtask

   task automatic do_reset_cycle(input int s);
      rst = 1'b1;
      mem_ready = 1'($urandom);
      emit(s, 1'b1, 1'b1);
      rst   = 1'b0;
      m_ret = 0;
      m_ill = 1'b0;
   endtask

   function automatic logic [5:0] pick_op();
      logic [5:0] legal_ops [6] = '{6'b100011, 6'b101011, 6'b000000,
                                    6'b000100, 6'b000010, 6'b001000};
      logic [5:0] o;
      int unsigned k;
      k = $urandom_range(0, 7);
      if (k < 6) return legal_ops[k];
      do o = 6'($urandom);
      while (o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000});
      return o;
   endfunction

   initial begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      do_reset_cycle(0);

      run_instr(6'b100011, 0, -1);
      run_instr(6'b000100, -1, 1);
      run_instr(6'b000100, -1, 0);
      run_instr(6'b111111, -1, -1);
      run_instr(6'b101011, 3, -1);
      run_instr(6'b001000, -1, -1);

      // reset arriving while the load sits in MEM_READ
      opcode = 6'b100011;
      mem_cycles(0, 0, -1);
      plain(1, -1);
      plain(2, -1);
`ifdef MEM_HANDSHAKE_EN
      mem_ready = 1'b0;
      emit(3, 1'b0, 1'b0);
`endif
      do_reset_cycle(3);

      for (int n = 0; n < 300; n++) begin
         if (n == 150) do_reset_cycle(0);
         else run_instr(pick_op(), -1, -1);
      end

      mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_controller.md
MIPS_MULTICYCLE_CONTROLLER -- requirements
Module: mips_multicycle_controller

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL: opcode  input  6  instruction[31:26], valid while ir is held.
REQ-004 SHALL: funct  input  6  instruction[5:0]; passed through only via alu_op decode.
REQ-005 SHALL: zero  input  1  ALU zero flag from datapath.
REQ-006 SHALL: mem_ready  input  1  memory completion strobe for the current access.
REQ-007 SHALL: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  standard multicycle datapath controls.
REQ-008 SHALL: alu_src_b, alu_op, pc_source  output  2 each  mux selects / ALU class (00 add, 01 sub, 10 funct).
REQ-009 SHALL: illegal_op  output  1  one-cycle pulse on undefined opcode.
REQ-010 SHALL: state  output  4  current FSM state encoding.
REQ-011 SHALL: retired  output  32  count of completed instructions.

Function
REQ-012 SHALL: Moore FSM, outputs decoded from the registered state only, except pc_en = pc_write | (pc_write_cond & zero) exposed as pc_write path inside datapath.
REQ-013 SHALL: states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
REQ-014 SHALL: FETCH asserts mem_read, ir_write, pc_write, alu_src_b=01, alu_op=00; advances to DECODE when the access completes (see REQ-024).
REQ-015 SHALL: DECODE (alu_src_b=11, alu_op=00) dispatches: 000000->EXECUTE, 100011/101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP, 001000->ADDI_EX, other->FETCH with illegal_op=1 for that one cycle.
REQ-016 SHALL: MEM_ADDR (alu_src_a=1, alu_src_b=10) -> MEM_READ for lw, MEM_WRITE for sw.
REQ-017 SHALL: MEM_READ (mem_read, i_or_d) -> MEM_WB on completion; MEM_WB (reg_write, mem_to_reg) -> FETCH.
REQ-018 SHALL: MEM_WRITE (mem_write, i_or_d) -> FETCH on completion.
REQ-019 SHALL: EXECUTE (alu_src_a=1, alu_op=10) -> R_WB (reg_dst, reg_write) -> FETCH.
REQ-020 SHALL: BRANCH (alu_src_a=1, alu_op=01, pc_write_cond, pc_source=01) -> FETCH; one cycle regardless of zero.
REQ-021 SHALL: JUMP (pc_write, pc_source=10) -> FETCH; ADDI_EX (alu_src_a=1, alu_src_b=10) -> ADDI_WB (reg_write) -> FETCH.
REQ-022 SHALL: all controls not listed for a state are 0; no control is asserted in two consecutive states unless listed.
REQ-023 SHALL: retired increments by 1 on every transition into FETCH from a terminal state (not from illegal dispatch), wrapping 0xFFFFFFFF->0.
REQ-024 SHALL: in memory states (FETCH, MEM_READ, MEM_WRITE) write-type strobes pc_write/ir_write/reg_write take effect only in the completing cycle.

Reset
REQ-025 SHALL: rst high at a clock edge forces state=FETCH, retired=0, illegal_op=0, abandoning any in-flight instruction or memory wait; rst dominates all other inputs.
REQ-026 SHALL: during rst all controls decode from FETCH but pc_write/ir_write/reg_write/mem_write are forced 0.

Configuration
REQ-027 SHALL: MEM_HANDSHAKE_EN defined: memory states hold (strobes gated off) until mem_ready=1, then advance; mem_read/mem_write stay asserted while waiting.
REQ-028 SHALL: MEM_HANDSHAKE_EN undefined: mem_ready ignored, every memory state completes in one cycle.

Structure
REQ-029 SHALL: state encodings, opcode constants and alu_op codes live in shared package mips_ctrl_pkg.
REQ-030 SHALL: output decode is sub-module mips_ctrl_decode (combinational, state in, controls out).

Verification
REQ-031 SHALL: rst=1 two cycles, release -> state=0, retired=0, FETCH controls visible next cycle.
REQ-032 SHALL: opcode=100011, mem_ready=1 -> states 0,1,2,3,4,0 over five cycles; reg_write&mem_to_reg only in state 4; retired=1.
REQ-033 SHALL: opcode=000100, zero=1 then zero=0 -> 0,1,8,0 each; pc_write_cond=1 only in state 8; retired=2.
REQ-034 SHALL: opcode=111111 -> 0,1,0, illegal_op=1 exactly one cycle, retired unchanged.
REQ-035 SHALL: MEM_HANDSHAKE_EN, sw with mem_ready low 3 cycles in MEM_WRITE -> state 5 held 4 cycles, mem_write high throughout, then FETCH.
REQ-036 SHALL: rst asserted while waiting in MEM_READ -> next state FETCH, retired=0.
